item_list_drawer: RTL and testbench

- Consumes the packed item list produced by the item map: 16 slots × 32 bits = 512 bits.
- Walks the slots and emits one pixel per cycle to the VGA plot interface.
- Each visible item is drawn as a filled square, coloured by item type. Erase mode paints the same squares in background colour.
- Sits between the item map and the VGA adapter. The game controller issues one start per frame, once in erase mode and once in draw mode.

---
 rtl/item_pkg.sv | 60 ++++++
 rtl/item_list_drawer_if.sv | 25 ++
 rtl/item_rect_scanner.sv | 40 ++++
 rtl/item_list_drawer.sv | 109 ++++++++++
 tb/tb_item_list_drawer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/item_pkg.sv
// rtl/item_pkg.sv - shared item slot layout, type codes, sizes and colours
package item_pkg;

    localparam int SLOT_W    = 32;
    localparam int MAX_SLOTS = 16;
    localparam int LIST_W    = SLOT_W * MAX_SLOTS;

    localparam int LEFT_HI   = 31;
    localparam int LEFT_LO   = 23;
    localparam int TOP_HI    = 18;
    localparam int TOP_LO    = 11;
    localparam int TYPE_HI   = 3;
    localparam int TYPE_LO   = 2;
    localparam int VIS_BIT   = 1;
    localparam int MOVED_BIT = 0;

    localparam logic [1:0] T_STONE   = 2'd0;
    localparam logic [1:0] T_GOLD    = 2'd1;
    localparam logic [1:0] T_DIAMOND = 2'd2;

    localparam logic [4:0] STONE_SIZE   = 5'd16;
    localparam logic [4:0] GOLD_SIZE    = 5'd16;
    localparam logic [4:0] DIAMOND_SIZE = 5'd8;

    localparam logic [8:0] Y_OFFSET = 9'd80;
    localparam logic [9:0] SCREEN_W = 10'd320;
    localparam logic [8:0] SCREEN_H = 9'd240;

    localparam logic [2:0] STONE_COLOUR   = 3'b111;
    localparam logic [2:0] GOLD_COLOUR    = 3'b110;
    localparam logic [2:0] DIAMOND_COLOUR = 3'b011;
    localparam logic [2:0] BG_COLOUR      = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_NEXT,
        S_DONE
    } draw_state_t;

    function automatic logic [4:0] item_size(input logic [1:0] t);
        case (t)
            T_GOLD:    return GOLD_SIZE;
            T_DIAMOND: return DIAMOND_SIZE;
            default:   return STONE_SIZE;
        endcase
    endfunction

    // Erase mode repaints the same footprint in background colour.
    function automatic logic [2:0] item_colour(input logic [1:0] t, input logic erase);
        if (erase) return BG_COLOUR;
        case (t)
            T_GOLD:    return GOLD_COLOUR;
            T_DIAMOND: return DIAMOND_COLOUR;
            default:   return STONE_COLOUR;
        endcase
    endfunction

endpackage

// File: rtl/item_list_drawer_if.sv
// rtl/item_list_drawer_if.sv - request and pixel-plot bundle of the item list drawer
interface item_list_drawer_if;
    import item_pkg::*;

    logic              start;
    logic              erase;
    logic [LIST_W-1:0] itemData;
    logic [4:0]        itemCount;
    logic              busy;
    logic              done;
    logic              plot;
    logic [8:0]        x;
    logic [7:0]        y;
    logic [2:0]        colour;

    modport master (
        output start, erase, itemData, itemCount,
        input  busy, done, plot, x, y, colour
    );

    modport slave (
        input  start, erase, itemData, itemCount,
        output busy, done, plot, x, y, colour
    );
endinterface

// File: rtl/item_rect_scanner.sv
// rtl/item_rect_scanner.sv - raster dx/dy counter over a size x size square
module item_rect_scanner (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       en,
    input  logic [4:0] size,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);
    logic [3:0] dx_q, dy_q;
    logic [4:0] edge_max;
    logic       row_end;

    assign edge_max = size - 5'd1;
    assign row_end  = ({1'b0, dx_q} == edge_max);

    // Row-major walk: dx sweeps a row, then dy steps down one line.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (load) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (en) begin
            if (row_end) begin
                dx_q <= '0;
                dy_q <= dy_q + 4'd1;
            end else begin
                dx_q <= dx_q + 4'd1;
            end
        end
    end

    assign dx   = dx_q;
    assign dy   = dy_q;
    assign last = row_end && ({1'b0, dy_q} == edge_max);
endmodule

// File: rtl/item_list_drawer.sv
// rtl/item_list_drawer.sv - walks the item snapshot and plots one pixel per cycle
module item_list_drawer
    import item_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    item_list_drawer_if.slave   bus
);
    draw_state_t       state_q, state_d;
    logic [LIST_W-1:0] snap_q;
    logic              erase_q;
    logic [4:0]        count_q;
    logic [4:0]        idx_q;
    logic [8:0]        left_q;
    logic [8:0]        ytop_q;
    logic [4:0]        size_q;
    logic [2:0]        colour_q;

    logic [SLOT_W-1:0] slot;
    logic [1:0]        slot_type;
    logic              slot_vis;
    logic              slot_unused;
    logic [4:0]        count_clamp;
    logic [3:0]        dx, dy;
    logic              last;
    logic [9:0]        px;
    logic [8:0]        py;
    logic              drawing;

    assign count_clamp = (bus.itemCount > 5'd16) ? 5'd16 : bus.itemCount;
    assign slot        = snap_q[{idx_q[3:0], 5'd0} +: SLOT_W];
    assign slot_type   = slot[TYPE_HI:TYPE_LO];
    assign slot_vis    = slot[VIS_BIT];
    // Spare slot bits and the moved flag are owned by the item map.
    assign slot_unused = ^{slot[LEFT_LO-1:TOP_HI+1], slot[TOP_LO-1:TYPE_HI+1], slot[MOVED_BIT]};

    item_rect_scanner u_scan (
        .clock  (clock),
        .resetn (resetn),
        .load   (state_q == S_LOAD),
        .en     (state_q == S_DRAW),
        .size   (size_q),
        .dx     (dx),
        .dy     (dy),
        .last   (last)
    );

    // State register; reset aborts a frame without a done pulse.
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: start is only honoured from idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = (count_clamp == 5'd0) ? S_DONE : S_LOAD;
            S_LOAD: state_d = (!slot_vis || slot_type == 2'd3) ? S_NEXT : S_DRAW;
            S_DRAW: if (last) state_d = S_NEXT;
            S_NEXT: state_d = ((idx_q + 5'd1) >= count_q) ? S_DONE : S_LOAD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame snapshot and per-item geometry, held stable for the whole square.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            snap_q   <= '0;
            erase_q  <= 1'b0;
            count_q  <= '0;
            idx_q    <= '0;
            left_q   <= '0;
            ytop_q   <= '0;
            size_q   <= '0;
            colour_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    snap_q  <= bus.itemData;
                    erase_q <= bus.erase;
                    count_q <= count_clamp;
                    idx_q   <= '0;
                end
                S_LOAD: begin
                    left_q   <= slot[LEFT_HI:LEFT_LO];
                    ytop_q   <= {1'b0, slot[TOP_HI:TOP_LO]} + Y_OFFSET;
                    size_q   <= item_size(slot_type);
                    colour_q <= item_colour(slot_type, erase_q);
                end
                S_NEXT: idx_q <= idx_q + 5'd1;
                default: ;
            endcase
        end
    end

    // Wide sums so off-screen pixels are rejected instead of wrapping.
    assign px      = {1'b0, left_q} + {6'd0, dx};
    assign py      = ytop_q + {5'd0, dy};
    assign drawing = (state_q == S_DRAW);

    assign bus.plot   = drawing && (px < SCREEN_W) && (py < SCREEN_H);
    assign bus.x      = drawing ? px[8:0] : '0;
    assign bus.y      = drawing ? py[7:0] : '0;
    assign bus.colour = drawing ? colour_q : '0;
    assign bus.busy   = (state_q == S_LOAD) || drawing || (state_q == S_NEXT);
    assign bus.done   = (state_q == S_DONE);
endmodule

// File: tb/tb_item_list_drawer.sv
// tb/tb_item_list_drawer.sv - scoreboard bench for item_list_drawer
module tb_item_list_drawer;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    item_list_drawer_if bus ();

    item_list_drawer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [19:0] sb[$];

    int s_left[16];
    int s_top[16];
    int s_vis[16];
    int s_type[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 16; i++) begin
            s_left[i] = 0; s_top[i] = 0; s_vis[i] = 0; s_type[i] = 0;
        end
    endtask

    task automatic set_slot(input int i, input int l, input int t, input int v, input int ty);
        s_left[i] = l; s_top[i] = t; s_vis[i] = v; s_type[i] = ty;
    endtask

    function automatic logic [511:0] pack_list();
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 16; i++)
            d[i*32 +: 32] = {9'(s_left[i]), 4'b0101, 8'(s_top[i]), 7'b1010011,
                             2'(s_type[i]), 1'(s_vis[i]), 1'b1};
        return d;
    endfunction

    // Reference: expected pixel stream and done cycle for the current slot table.
    task automatic model(input int cnt, input logic er, output int done_cyc);
        int n, len, sz, px, py;
        logic [2:0] c;
        n   = (cnt > 16) ? 16 : cnt;
        len = 2;
        for (int i = 0; i < n; i++) begin
            if (s_vis[i] != 0 && s_type[i] != 3) begin
                sz = (s_type[i] == 2) ? 8 : 16;
                if (er)               c = 3'b100;
                else if (s_type[i] == 0) c = 3'b111;
                else if (s_type[i] == 1) c = 3'b110;
                else                  c = 3'b011;
                for (int yy = 0; yy < sz; yy++)
                    for (int xx = 0; xx < sz; xx++) begin
                        px = s_left[i] + xx;
                        py = s_top[i] + 80 + yy;
                        if (px < 320 && py < 240) sb.push_back({9'(px), 8'(py), c});
                    end
                len += sz * sz + 2;
            end else begin
                len += 2;
            end
        end
        done_cyc = len - 1;
    endtask

    task automatic run_frame(input int cnt, input logic er, input int poke_cyc, input string tag);
        int exp_done, cyc, got_done;
        logic [19:0] e;
        sb.delete();
        model(cnt, er, exp_done);
        bus.itemData  = pack_list();
        bus.itemCount = 5'(cnt);
        bus.erase     = er;
        @(posedge clock); #1;
        bus.start = 1'b1;
        cyc = 0;
        got_done = -1;
        while (got_done < 0 && cyc < 3000) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            cyc++;
            if (cyc == poke_cyc) begin
                bus.itemData  = ~bus.itemData;
                bus.itemCount = 5'd16;
                bus.erase     = ~er;
                bus.start     = 1'b1;
            end
            chk({tag, " busy"}, {31'd0, bus.busy}, (cyc < exp_done) ? 32'd1 : 32'd0);
            if (bus.plot) begin
                if (sb.size() == 0) begin
                    chk({tag, " extra pixel"}, {12'd0, bus.x, bus.y, bus.colour}, 32'hFFFFFFFF);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " pixel"}, {12'd0, bus.x, bus.y, bus.colour}, {12'd0, e});
                end
            end
            if (bus.done) got_done = cyc;
        end
        chk({tag, " done cycle"}, got_done, exp_done);
        chk({tag, " pixels left"}, sb.size(), 0);
        @(posedge clock); #1;
        chk({tag, " idle after done"}, {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.erase = 1'b0; bus.itemData = '0; bus.itemCount = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset outputs", {8'd0, bus.busy, bus.done, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            chk("idle outputs", {8'd0, bus.busy, bus.done, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
        end

        clear_slots();
        set_slot(0, 10, 5, 1, 1);
        run_frame(1, 1'b0, 0, "gold");

        clear_slots();
        set_slot(0, 100, 20, 1, 0);
        set_slot(1, 50, 30, 0, 0);
        set_slot(2, 0, 0, 1, 2);
        run_frame(3, 1'b0, 0, "three");
        run_frame(3, 1'b1, 0, "erase");
        run_frame(3, 1'b0, 30, "snapshot");

        clear_slots();
        set_slot(0, 315, 0, 1, 0);
        run_frame(1, 1'b0, 0, "clip x");

        clear_slots();
        set_slot(0, 40, 155, 1, 1);
        run_frame(1, 1'b0, 0, "clip y");

        clear_slots();
        set_slot(0, 60, 60, 1, 3);
        set_slot(15, 200, 100, 1, 2);
        run_frame(31, 1'b0, 0, "clamp");

        run_frame(0, 1'b0, 0, "zero");

        clear_slots();
        set_slot(0, 10, 5, 1, 1);
        bus.itemData  = pack_list();
        bus.itemCount = 5'd1;
        bus.erase     = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (49) @(posedge clock);
        #1;
        chk("pre-reset plot", {31'd0, bus.plot}, 32'd1);
        resetn = 1'b0;
        @(posedge clock); #1;
        chk("abort outputs", {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            chk("post-abort quiet", {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
